// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
// Shares one 32-bit signed carry-lookahead adder among NUM_REQ requesters.
// A round-robin arbiter grants one request at a time. The winner's operands
// are latched in the grant cycle and summed in EXEC. The registered result
// is then held on a tagged response channel until the consumer accepts it.

module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ-1:0]    req_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_sum,
    output logic                  rsp_cout,
    output logic                  rsp_ovf,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_grant;

    logic [ID_W-1:0] r_ptr;
    logic            w_found;
    logic [ID_W-1:0] w_winner;
    logic [ID_W-1:0] w_cand;
    int              w_idx;

    logic [31:0]     w_sel_a;
    logic [31:0]     w_sel_b;
    logic            w_sel_cin;

    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic            r_cin;
    logic [ID_W-1:0] r_id;

    logic [32:0]     w_sum33;
    logic [31:0]     r_sum;
    logic            r_cout;
    logic            r_ovf;
    logic [ID_W-1:0] r_rsp_id;
    logic            r_rsp_valid;
    logic            r_busy;

    // 32-bit adder built from 4-bit carry-lookahead groups. Inside each group,
    // every carry comes directly from the group's carry-in. Only the group
    // carries pass from one group to the next.
    function automatic logic [32:0] cla_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        cin);
        logic [31:0] g;
        logic [31:0] p;
        logic [32:0] c;
        logic        gg;
        logic        gp;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        for (int k = 0; k < 8; k++) begin
            gg = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp = &p[4*k +: 4];
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+4] = gg | (gp & c[4*k]);
        end
        return {c[32], p ^ c[31:0]};
    endfunction

    // Round-robin search: the first valid requester at or after ptr, wrapping around.
    always_comb begin
        // NOTE: every variable gets a default before the loop. Then no path
        // leaves a value unassigned, and no latch is inferred.
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        w_cand   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_idx = int'(r_ptr) + off;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            w_cand = ID_W'(w_idx);
            if (!w_found && req_valid[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // Operand multiplexer that selects the winner's A, B and carry-in.
    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_cin = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_sel_a   = req_a[32*i +: 32];
                w_sel_b   = req_b[32*i +: 32];
                w_sel_cin = req_cin[i];
            end
        end
    end

    // FSM next-state logic and the combinational grant.
    always_comb begin
        // NOTE: always_comb uses blocking assignments, so later statements
        // see the values assigned earlier in the same pass.
        w_state_nxt = r_state;
        req_ready   = '0;
        w_grant     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found && rst_n) begin
                    req_ready[w_winner] = 1'b1;
                    w_grant             = 1'b1;
                    w_state_nxt         = EXEC;
                end
            end
            EXEC:    w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register, plus the registered status outputs taken from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // NOTE: flops use non-blocking assignments, so every register
            // samples its pre-edge inputs and no process ordering is assumed.
            r_state     <= w_state_nxt;
            r_rsp_valid <= (w_state_nxt == RESP);
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    // Latches the winner's operands and tag, and advances the pointer, on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these are a handful of flops, not a memory array. Resetting
            // them costs little and keeps every value that reaches an output defined.
            r_a   <= '0;
            r_b   <= '0;
            r_cin <= 1'b0;
            r_id  <= '0;
            r_ptr <= '0;
        end else if (w_grant) begin
            r_a   <= w_sel_a;
            r_b   <= w_sel_b;
            r_cin <= w_sel_cin;
            r_id  <= w_winner;
            r_ptr <= (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
        end
    end

    assign w_sum33 = cla_add(r_a, r_b, r_cin);

    // Captures the adder result in EXEC. It then stays stable for all of RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_rsp_id <= '0;
        end else if (r_state == EXEC) begin
            r_sum    <= w_sum33[31:0];
            r_cout   <= w_sum33[32];
            r_ovf    <= (r_a[31] == r_b[31]) && (w_sum33[31] != r_a[31]);
            r_rsp_id <= r_id;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_cout;
    assign rsp_ovf   = r_ovf;
    assign busy      = r_busy;

endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin arbiter and sequencer that shares one 32-bit signed carry-lookahead adder datapath among NUM_REQ independent requesters. It accepts one operand set at a time through a valid/ready handshake and latches the operands. It then registers the sum, carry-out and signed-overflow flag, and returns them on a common response channel tagged with the requester index. It sits between client blocks, such as address generators and accumulators, and the shared adder, so that none of them needs a private adder.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..8.
- ID_W, 2: response tag width; must equal ceil(log2(NUM_REQ)).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant. One-hot or zero.
- req_a  in  NUM_REQ*32  operand A of requester i, packed at bits [32i+31:32i], signed.
- req_b  in  NUM_REQ*32  operand B, same packing, signed.
- req_cin  in  NUM_REQ  carry-in of requester i.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_sum  out  32  A+B+cin, modulo 2^32.
- rsp_cout  out  1  carry out of bit 31.
- rsp_ovf  out  1  signed overflow.
- busy  out  1  high whenever state is not IDLE.

## Operation
- State machine states: IDLE, EXEC and RESP. The state register resets to IDLE.
- IDLE state:
  - Winner = first i with req_valid[i]=1, searching ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - req_ready[winner]=1 combinationally; all other bits are 0.
  - If any request is valid, the block latches the winner's A, B, cin and index, and moves to EXEC.
  - ptr ← (winner+1) mod NUM_REQ.
- EXEC state:
  - The shared adder computes from the latched operands.
  - At the end of the cycle the block registers:
    - sum[31:0] and cout from the 33-bit result of A+B+cin.
    - ovf = (A[31]==B[31]) && (sum[31]!=A[31]).
  - Next state is RESP.
- RESP state:
  - rsp_valid=1. rsp_id, rsp_sum, rsp_cout and rsp_ovf hold stable until the response handshake.
  - On rsp_valid && rsp_ready the next state is IDLE. Otherwise the block stays in RESP (backpressure).
- req_ready is all-zero in EXEC and RESP, regardless of req_valid.
- ptr changes only on a grant. It resets to 0.
- Requests that keep req_valid high keep competing. A requester is never granted twice in a row while another requester is valid (fairness).
- The handshake follows valid/ready rules: a requester must hold req_valid and its operands stable until req_ready. The block does not sample a request whose req_valid is low.
- Reset mid-operation: the in-flight operation is discarded with no response, and ptr returns to 0.

## Timing
- Reset values:
  - rsp_valid=0, busy=0.
  - rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0.
  - req_ready=0 while rst_n=0.
- Latency: a grant in cycle T puts rsp_valid high in cycle T+2.
- Minimum occupancy is 3 cycles per operation: grant, EXEC, and RESP with rsp_ready=1. Peak throughput is therefore one operation per 3 cycles.
- No grant is issued in the cycle in which a response handshake completes. The next grant occurs one cycle later, in IDLE.
- All outputs except req_ready are driven directly from registers. req_ready is combinational from the state, ptr and req_valid.

## Test plan
- Single op: requester 0 sends A=0x00000005, B=0x00000003, cin=1 with rsp_ready tied to 1.
  - Required: req_ready[0] in cycle T; rsp_valid in cycle T+2 with sum=0x00000009, cout=0, ovf=0, id=0.
- Overflow and carry:
  - A=0x7FFFFFFF, B=0x00000001, cin=0 → sum=0x80000000, ovf=1, cout=0.
  - A=0xFFFFFFFF, B=0x00000001 → sum=0, cout=1, ovf=0.
  - A=0x80000000, B=0x80000000 → sum=0, cout=1, ovf=1.
- Round-robin: all 4 requesters hold req_valid.
  - Required: grants in order 0, 1, 2, 3, 0, with one grant every 3 cycles and each rsp_id matching its grant.
- Backpressure: hold rsp_ready=0 for 5 cycles while in RESP.
  - Required: rsp_* stable, req_ready=0 and busy=1 throughout. The handshake completes on the first cycle with rsp_ready=1.
- Reset mid-operation: assert rst_n=0 during EXEC.
  - Required: rsp_valid=0 and busy=0 immediately (asynchronously). After release, the first grant goes to the lowest valid index starting from ptr=0.
- Wrap-around: with ptr=3, only requesters 1 and 3 valid.
  - Required: grant 3, then grant 1.
